idu_hazard_ctrl: RTL and testbench

- Scoreboard and issue scheduler for the decode stage; it drives the decoder's stall output, which is currently tied to 0.
- Tracks GPR destinations of in-flight long-latency ops (loads, mul/div) and holds decode on RAW/WAW hazards.
- Holds decode when the outstanding-op limit is reached, or when a divide would issue while the single divider is busy.
- Sits between the decoder outputs and the id_ex register; receives completion pulses from execute/writeback.

---
 rtl/idu_hazard_pkg.sv | 12 +
 rtl/idu_scoreboard.sv | 42 ++++
 rtl/idu_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_idu_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/idu_hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package idu_hazard_pkg;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    localparam int unsigned GPR_NUM = 32;
    localparam int unsigned GPR_AW  = 5;

endpackage

// File: rtl/idu_scoreboard.sv
// GPR pending-write scoreboard with a completion-bypassed combinational read port.
module idu_scoreboard
    import idu_hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [GPR_AW-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [GPR_AW-1:0] clr_addr_i,
    input  logic [GPR_AW-1:0] rs1_addr_i,
    input  logic [GPR_AW-1:0] rs2_addr_i,
    input  logic [GPR_AW-1:0] rd_addr_i,
    output logic              rs1_hit_o,
    output logic              rs2_hit_o,
    output logic              rd_hit_o
);

    logic [GPR_NUM-1:0] sb_q, sb_d;
    logic [GPR_NUM-1:0] set_mask, clr_mask, sb_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_addr_i] = 1'b1;
        if (clr_i) clr_mask[clr_addr_i] = 1'b1;
        // Completing write lands in the GPR this cycle, so readers see it cleared.
        sb_eff = sb_q & ~clr_mask;
        // Set after clear: a same-index re-issue keeps the bit; x0 never tracked.
        sb_d   = (sb_eff | set_mask) & ~GPR_NUM'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign rs1_hit_o = sb_eff[rs1_addr_i] & (rs1_addr_i != '0);
    assign rs2_hit_o = sb_eff[rs2_addr_i] & (rs2_addr_i != '0);
    assign rd_hit_o  = sb_eff[rd_addr_i]  & (rd_addr_i  != '0);

endmodule

// File: rtl/idu_hazard_ctrl.sv
// Decode-stage hazard controller: RAW/WAW scoreboard, outstanding-op cap, divider busy.
// Optional stall-cycle counter enabled by IDU_HAZARD_PERF_CNT_EN.
module idu_hazard_ctrl
    import idu_hazard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid_i,
    input  logic [GPR_AW-1:0] rs1_raddr_i,
    input  logic [GPR_AW-1:0] rs2_raddr_i,
    input  logic [GPR_AW-1:0] rd_waddr_i,
    input  logic              rd_we_i,
    input  logic              dec_long_i,
    input  logic              dec_div_i,
    input  logic              flush_i,
    input  logic              wb_valid_i,
    input  logic [GPR_AW-1:0] wb_waddr_i,
    input  logic              wb_div_i,
    output logic              stall_o,
    output logic              issue_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    div_state_e       div_q, div_d;
    logic             err_q;
    logic             rs1_hit, rs2_hit, rd_hit;
    logic             raw, waw, cap, divb;
    logic             inc, dec;

    idu_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (issue_o & dec_long_i & rd_we_i),
        .set_addr_i (rd_waddr_i),
        .clr_i      (wb_valid_i),
        .clr_addr_i (wb_waddr_i),
        .rs1_addr_i (rs1_raddr_i),
        .rs2_addr_i (rs2_raddr_i),
        .rd_addr_i  (rd_waddr_i),
        .rs1_hit_o  (rs1_hit),
        .rs2_hit_o  (rs2_hit),
        .rd_hit_o   (rd_hit)
    );

    assign raw  = rs1_hit | rs2_hit;
    assign waw  = rd_we_i & rd_hit;
    assign cap  = dec_long_i & (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~wb_valid_i;
    assign divb = dec_div_i & (div_q == DIV_BUSY) & ~(wb_valid_i & wb_div_i);

    assign stall_o = dec_valid_i & ~flush_i & (raw | waw | cap | divb);
    assign issue_o = dec_valid_i & ~flush_i & ~stall_o;

    // A completion with nothing outstanding is an error and must not underflow.
    assign inc = issue_o & dec_long_i;
    assign dec = wb_valid_i & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        div_d = div_q;
        case (div_q)
            DIV_IDLE: if (issue_o & dec_div_i) div_d = DIV_BUSY;
            DIV_BUSY: if (wb_valid_i & wb_div_i & ~(issue_o & dec_div_i)) div_d = DIV_IDLE;
            default:  div_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= DIV_IDLE;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            err_q <= wb_valid_i & (cnt_q == '0);
        end
    end

    assign busy_o = (cnt_q != '0);
    assign err_o  = err_q;

`ifdef IDU_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       stall_cnt_q <= '0;
        else if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// Directed self-checking bench for idu_hazard_ctrl (MAX_OUTSTANDING=2).
module tb_idu_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid_i, rd_we_i, dec_long_i, dec_div_i, flush_i;
    logic [4:0]  rs1_raddr_i, rs2_raddr_i, rd_waddr_i, wb_waddr_i;
    logic        wb_valid_i, wb_div_i;
    logic        stall_o, issue_o, busy_o, err_o;
    logic [31:0] stall_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    idu_hazard_ctrl #(.MAX_OUTSTANDING(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid_i (dec_valid_i),
        .rs1_raddr_i (rs1_raddr_i),
        .rs2_raddr_i (rs2_raddr_i),
        .rd_waddr_i  (rd_waddr_i),
        .rd_we_i     (rd_we_i),
        .dec_long_i  (dec_long_i),
        .dec_div_i   (dec_div_i),
        .flush_i     (flush_i),
        .wb_valid_i  (wb_valid_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_div_i    (wb_div_i),
        .stall_o     (stall_o),
        .issue_o     (issue_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction in the decode slot; inputs change 1 time unit after the rising edge.
    task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic lng,
                       input logic dv, input logic fl);
        dec_valid_i = v;   rs1_raddr_i = rs1; rs2_raddr_i = rs2; rd_waddr_i = rd;
        rd_we_i     = we;  dec_long_i  = lng; dec_div_i   = dv;  flush_i    = fl;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic d);
        wb_valid_i = v; wb_waddr_i = a; wb_div_i = d;
    endtask

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_si(input string tag, input logic s, input logic i);
        #1;
        chk({tag, "_stall"}, {31'b0, stall_o}, {31'b0, s});
        chk({tag, "_issue"}, {31'b0, issue_o}, {31'b0, i});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk_si("rst", 0, 0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_err",  {31'b0, err_o},  32'd0);
        chk("rst_scnt", stall_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load-use RAW with same-cycle completion bypass
        dec(1, 0, 0, 5, 1, 1, 0, 0);       chk_si("lw5", 0, 1);
        tick(); chk("lw5_busy", {31'b0, busy_o}, 32'd1);
        dec(1, 5, 1, 6, 1, 0, 0, 0);       chk_si("raw5_a", 1, 0);
        tick();                             chk_si("raw5_b", 1, 0);
        tick(); wb(1, 5, 0);                chk_si("raw5_byp", 0, 1);
        tick(); idle();
        chk("raw5_busy", {31'b0, busy_o}, 32'd0);
        chk("raw5_err",  {31'b0, err_o},  32'd0);

        // x0 destination and WAW
        dec(1, 0, 0, 0, 1, 1, 0, 0);       chk_si("lw0", 0, 1);
        tick(); chk("lw0_cnt", {30'b0, u_dut.cnt_q}, 32'd1);
        dec(1, 0, 0, 0, 1, 0, 0, 0);       chk_si("addi0", 0, 1);
        tick(); dec(1, 0, 0, 7, 1, 1, 0, 0); chk_si("lw7", 0, 1);
        tick(); chk("lw7_cnt", {30'b0, u_dut.cnt_q}, 32'd2);
        dec(1, 1, 0, 7, 1, 0, 0, 0);       chk_si("waw7", 1, 0);
        tick(); wb(1, 7, 0);                chk_si("waw7_byp", 0, 1);
        tick(); idle(); wb(1, 0, 0);
        tick(); idle();
        chk("x0_drain_busy", {31'b0, busy_o}, 32'd0);
        chk("x0_drain_err",  {31'b0, err_o},  32'd0);

        // Capacity limit with a same-cycle completion
        dec(1, 0, 0, 3, 1, 1, 0, 0);       chk_si("lw3", 0, 1);
        tick(); dec(1, 0, 0, 4, 1, 1, 0, 0); chk_si("lw4", 0, 1);
        tick(); chk("cap_cnt", {30'b0, u_dut.cnt_q}, 32'd2);
        dec(1, 0, 0, 8, 1, 1, 0, 0);       chk_si("cap_a", 1, 0);
        tick();                             chk_si("cap_b", 1, 0);
        tick(); wb(1, 3, 0);                chk_si("cap_wb", 0, 1);
        tick(); idle();
        chk("cap_cnt2", {30'b0, u_dut.cnt_q}, 32'd2);
        wb(1, 4, 0); tick(); wb(1, 8, 0); tick(); idle();
        chk("cap_drain", {31'b0, busy_o}, 32'd0);

        // Single divider
        dec(1, 0, 0, 9, 1, 1, 1, 0);       chk_si("div9", 0, 1);
        tick(); dec(1, 0, 0, 10, 1, 1, 1, 0); chk_si("divb_a", 1, 0);
        tick();                             chk_si("divb_b", 1, 0);
        tick(); wb(1, 9, 1);                chk_si("divb_wb", 0, 1);
        tick(); wb(0, 0, 0); dec(1, 0, 0, 11, 1, 1, 1, 0);
        chk_si("div_still_busy", 1, 0);
        tick(); wb(1, 10, 1);               chk_si("div11", 0, 1);
        tick(); dec(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 11, 1);
        tick(); idle();
        chk("div_drain", {31'b0, busy_o}, 32'd0);
        dec(1, 0, 0, 12, 1, 1, 1, 0);      chk_si("div_idle", 0, 1);
        tick(); dec(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 12, 1);
        tick(); idle();

        // Flush during a hazard, then a stray completion
        dec(1, 0, 0, 12, 1, 1, 0, 0);      chk_si("lw12", 0, 1);
        tick(); dec(1, 12, 0, 13, 1, 0, 0, 1); chk_si("flush", 0, 0);
        tick(); dec(1, 12, 0, 13, 1, 0, 0, 0); chk_si("post_flush", 1, 0);
        tick(); dec(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 12, 0);
        tick(); idle();
        chk("fl_busy", {31'b0, busy_o}, 32'd0);
        chk("fl_err0", {31'b0, err_o},  32'd0);
        wb(1, 13, 0);
        tick(); idle();
        chk("err_pulse", {31'b0, err_o}, 32'd1);
        chk("err_cnt",   {30'b0, u_dut.cnt_q}, 32'd0);
        tick();
        chk("err_gone",  {31'b0, err_o}, 32'd0);

        // Reset mid-operation
        dec(1, 0, 0, 14, 1, 1, 0, 0); tick();
        dec(1, 0, 0, 15, 1, 1, 0, 0); tick(); idle();
        chk("mid_busy", {31'b0, busy_o}, 32'd1);
        rst_n = 1'b0; #2;
        chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
        chk("rstmid_cnt",  {30'b0, u_dut.cnt_q}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        dec(1, 14, 15, 16, 1, 0, 0, 0);    chk_si("rstmid_sb", 0, 1);
        tick();

        // Five-cycle stall for the optional counter
        dec(1, 0, 0, 20, 1, 1, 0, 0); tick();
        dec(1, 20, 0, 21, 1, 0, 0, 0);
        repeat (5) tick();
        idle(); #1;
`ifdef IDU_HAZARD_PERF_CNT_EN
        chk("scnt", stall_cnt_o, 32'd5);
`else
        chk("scnt", stall_cnt_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
